// File: rtl/read_stage_mp.sv
// Register-read stage: scoreboard-checked issue of decoded insns to execute through a single
// output register, with backpressure, hazard stall, writeback clear, flush and a stall counter.
`timescale 1ns/1ps

module read_stage_mp #(
    parameter int ADDR_WIDTH    = 32,
    parameter int INSN_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int NR_RD_PORTS   = 2,
    parameter int ZERO_REG      = 1,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADDR_WIDTH-1:0]                 in_addr,
    input  logic [INSN_WIDTH-1:0]                 in_insn,
    input  logic [NR_RD_PORTS-1:0]                in_src_en,
    input  logic [NR_RD_PORTS*RF_ADDR_WIDTH-1:0]  in_src_addr,
    input  logic                                  in_dst_en,
    input  logic [RF_ADDR_WIDTH-1:0]              in_dst_addr,
    input  logic                                  in_sreg_en,
    input  logic [9:0]                            in_sreg_id,
    input  logic                                  wb_en,
    input  logic [RF_ADDR_WIDTH-1:0]              wb_addr,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADDR_WIDTH-1:0]                 out_addr,
    output logic [INSN_WIDTH-1:0]                 out_insn,
    output logic [NR_RD_PORTS-1:0]                rf_rd_en,
    output logic [NR_RD_PORTS*RF_ADDR_WIDTH-1:0]  rf_rd_addr,
    output logic                                  sreg_rd_en,
    output logic [4:0]                            sreg_rd_group,
    output logic [2:0]                            sreg_rd_regnum,
    output logic [1:0]                            sreg_rd_plevel,
    output logic [STALL_CNT_W-1:0]                stall_cnt
);

    localparam int NR_REGS = 1 << RF_ADDR_WIDTH;
    localparam int SRC_W   = NR_RD_PORTS * RF_ADDR_WIDTH;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic is_zero_reg(input logic [RF_ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == {RF_ADDR_WIDTH{1'b0}});
    endfunction

    // A register blocks only if still busy after this cycle's writeback bypass.
    function automatic logic reg_blocks(input logic [NR_REGS-1:0]       busy,
                                        input logic [RF_ADDR_WIDTH-1:0] idx,
                                        input logic                     wb_v,
                                        input logic [RF_ADDR_WIDTH-1:0] wb_idx);
        return busy[idx] & ~(wb_v & (wb_idx == idx)) & ~is_zero_reg(idx);
    endfunction

    logic [NR_REGS-1:0]       busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
    logic [INSN_WIDTH-1:0]    out_insn_q, out_insn_d;
    logic [NR_RD_PORTS-1:0]   rf_rd_en_q, rf_rd_en_d;
    logic [SRC_W-1:0]         rf_rd_addr_q, rf_rd_addr_d;
    logic                     sreg_rd_en_q, sreg_rd_en_d;
    logic [4:0]               sreg_group_q, sreg_group_d;
    logic [2:0]               sreg_regnum_q, sreg_regnum_d;
    logic [1:0]               sreg_plevel_q, sreg_plevel_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NR_RD_PORTS-1:0]   src_hit_s;
    logic                     dst_hit_s;
    logic                     hazard_s;
    logic                     in_ready_s;
    logic                     accept_s;

    // Hazard detection and input handshake.
    always_comb begin
        src_hit_s = '0;
        for (int p = 0; p < NR_RD_PORTS; p++) begin
            src_hit_s[p] = in_src_en[p] &
                reg_blocks(busy_q, in_src_addr[p*RF_ADDR_WIDTH +: RF_ADDR_WIDTH], wb_en, wb_addr);
        end
        dst_hit_s  = in_dst_en & reg_blocks(busy_q, in_dst_addr, wb_en, wb_addr);
        hazard_s   = (|src_hit_s) | dst_hit_s;
        in_ready_s = rst_n & ~flush & ~hazard_s & (~out_valid_q | out_ready);
        accept_s   = in_valid & in_ready_s;
    end

    // Scoreboard update: flush clears all, a new destination beats a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NR_REGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (accept_s & in_dst_en & ~is_zero_reg(in_dst_addr) &
                         (in_dst_addr == r[RF_ADDR_WIDTH-1:0])) begin
                busy_d[r] = 1'b1;
            end else if (wb_en & (wb_addr == r[RF_ADDR_WIDTH-1:0])) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Output register next-state: load on accept, drain on consume, kill on flush.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_insn_d    = out_insn_q;
        rf_rd_en_d    = rf_rd_en_q;
        rf_rd_addr_d  = rf_rd_addr_q;
        sreg_rd_en_d  = sreg_rd_en_q;
        sreg_group_d  = sreg_group_q;
        sreg_regnum_d = sreg_regnum_q;
        sreg_plevel_d = sreg_plevel_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            rf_rd_en_d   = '0;
            sreg_rd_en_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d  = 1'b1;
            out_addr_d   = in_addr;
            out_insn_d   = in_insn;
            rf_rd_en_d   = in_src_en;
            rf_rd_addr_d = in_src_addr;
            sreg_rd_en_d = in_sreg_en;
            if (in_sreg_en) begin
                sreg_group_d  = in_sreg_id[9:5];
                sreg_regnum_d = in_sreg_id[4:2];
                sreg_plevel_d = in_sreg_id[1:0];
            end else begin
                sreg_group_d  = sreg_group_q;
                sreg_regnum_d = sreg_regnum_q;
                sreg_plevel_d = sreg_plevel_q;
            end
        end else if (out_valid_q & out_ready) begin
            out_valid_d  = 1'b0;
            rf_rd_en_d   = '0;
            sreg_rd_en_d = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Saturating count of cycles where decode is held off.
    always_comb begin
        if (in_valid & ~in_ready_s & ~flush & rst_n) begin
            if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_d = stall_cnt_q + STALL_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_insn_q    <= '0;
            rf_rd_en_q    <= '0;
            rf_rd_addr_q  <= '0;
            sreg_rd_en_q  <= 1'b0;
            sreg_group_q  <= 5'd0;
            sreg_regnum_q <= 3'd0;
            sreg_plevel_q <= 2'd0;
            stall_cnt_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_insn_q    <= out_insn_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_rd_addr_q  <= rf_rd_addr_d;
            sreg_rd_en_q  <= sreg_rd_en_d;
            sreg_group_q  <= sreg_group_d;
            sreg_regnum_q <= sreg_regnum_d;
            sreg_plevel_q <= sreg_plevel_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_q;
    assign out_addr       = out_addr_q;
    assign out_insn       = out_insn_q;
    assign rf_rd_en       = rf_rd_en_q;
    assign rf_rd_addr     = rf_rd_addr_q;
    assign sreg_rd_en     = sreg_rd_en_q;
    assign sreg_rd_group  = sreg_group_q;
    assign sreg_rd_regnum = sreg_regnum_q;
    assign sreg_rd_plevel = sreg_plevel_q;
    assign stall_cnt      = stall_cnt_q;

endmodule
